// File: rtl/fifo_pkg.sv
// Shared FIFO pointer helpers for the write- and read-side controllers.
// Gray helpers work on a wide word; callers zero-extend and truncate.
package fifo_pkg;

  localparam int DEF_ADDR_WIDTH = 3;
  localparam int GW = 32;

  typedef logic [GW-1:0] gword_t;

  function automatic int pw_of(int aw);
    return aw + 1;
  endfunction

  function automatic gword_t bin2gray(gword_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic gword_t gray2bin(gword_t g);
    gword_t b;
    b[GW-1] = g[GW-1];
    for (int i = GW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wr_ctrl_if.sv
// Write-side FIFO controller bus: producer/memory side vs controller.
// Adds W_ALMOST_FULL when FIFO_ALMOST_FULL_EN is defined.
interface fifo_wr_ctrl_if
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  localparam int PW = pw_of(ADDR_WIDTH);

  logic                  W_INC;
  logic [PW-1:0]         R_PTR_GRAY;
  logic                  W_EN;
  logic [ADDR_WIDTH-1:0] W_ADDR;
  logic [PW-1:0]         W_PTR_GRAY;
  logic                  W_FULL;
`ifdef FIFO_ALMOST_FULL_EN
  logic                  W_ALMOST_FULL;

  modport master (
    output W_INC, R_PTR_GRAY,
    input  W_EN, W_ADDR, W_PTR_GRAY,
    input  W_FULL, W_ALMOST_FULL
  );

  modport slave (
    input  W_INC, R_PTR_GRAY,
    output W_EN, W_ADDR, W_PTR_GRAY,
    output W_FULL, W_ALMOST_FULL
  );
`else
  modport master (
    output W_INC, R_PTR_GRAY,
    input  W_EN, W_ADDR, W_PTR_GRAY,
    input  W_FULL
  );

  modport slave (
    input  W_INC, R_PTR_GRAY,
    output W_EN, W_ADDR, W_PTR_GRAY,
    output W_FULL
  );
`endif

endinterface

// File: rtl/fifo_gray_sync.sv
// Two-flop synchroniser for a Gray pointer crossing clock domains.
// Synchronous active-low reset; shared by write and read controllers.
module fifo_gray_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q1 <= '0;
      q  <= '0;
    end else begin
      q1 <= d;
      q  <= q1;
    end
  end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Async FIFO write-side controller: pointers, Gray export, full flag.
// Optional W_ALMOST_FULL output under macro FIFO_ALMOST_FULL_EN.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input logic            W_CLK,
  input logic            W_RST,
  fifo_wr_ctrl_if.slave  bus
);

  localparam int PW = pw_of(ADDR_WIDTH);

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rq2;
  logic [PW-1:0] full_cmp;
  logic          full;
  logic          full_next;
  logic          accept;

  fifo_gray_sync #(
    .WIDTH (PW)
  ) u_rsync (
    .clk   (W_CLK),
    .rst_n (W_RST),
    .d     (bus.R_PTR_GRAY),
    .q     (rq2)
  );

  always_comb begin
    accept     = bus.W_INC & ~full;
    wbin_next  = wbin + {{(PW-1){1'b0}}, accept};
    wgray_next = PW'(bin2gray(GW'(wbin_next)));
    // Full: write pointer one lap ahead of the synced read pointer
    full_cmp   = {~rq2[PW-1:PW-2], rq2[PW-3:0]};
    full_next  = (wgray_next == full_cmp);
  end

  always_ff @(posedge W_CLK) begin
    if (!W_RST) begin
      wbin  <= '0;
      wgray <= '0;
      full  <= 1'b0;
    end else begin
      wbin  <= wbin_next;
      wgray <= wgray_next;
      full  <= full_next;
    end
  end

  assign bus.W_EN       = accept;
  assign bus.W_ADDR     = wbin[ADDR_WIDTH-1:0];
  assign bus.W_PTR_GRAY = wgray;
  assign bus.W_FULL     = full;

`ifdef FIFO_ALMOST_FULL_EN
  logic [PW-1:0] rbin;
  logic [PW-1:0] used;
  logic          afull;
  logic          afull_next;

  always_comb begin
    rbin       = PW'(gray2bin(GW'(rq2)));
    used       = wbin_next - rbin;
    afull_next = (used >= PW'((1 << ADDR_WIDTH) - 1)) | full_next;
  end

  always_ff @(posedge W_CLK) begin
    if (!W_RST) begin
      afull <= 1'b0;
    end else begin
      afull <= afull_next;
    end
  end

  assign bus.W_ALMOST_FULL = afull;
`endif

endmodule

// File: doc/fifo_wr_ctrl.md
FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 3, FIFO address width; depth = 2^ADDR_WIDTH = 8; pointer width PW = ADDR_WIDTH+1 = 4.
REQ-002 W_CLK  input  1  write-domain clock; one clock, all flops rising-edge W_CLK.
REQ-003 W_RST  input  1  reset, synchronous, active-low.
REQ-004 W_INC  input  1  write request from producer.
REQ-005 R_PTR_GRAY  input  PW  read pointer, Gray, from read domain, unsynchronised.
REQ-006 W_EN  output  1  memory write enable.
REQ-007 W_ADDR  output  ADDR_WIDTH  memory write address.
REQ-008 W_PTR_GRAY  output  PW  registered Gray write pointer, to read domain.
REQ-009 W_FULL  output  1  FIFO full, registered.

Function
REQ-010 Internal binary pointer wbin (PW bits) SHALL increment by 1 on a W_CLK edge iff W_INC=1 and W_FULL=0; otherwise hold.
REQ-011 wbin SHALL wrap modulo 2^PW (1111 -> 0000), no saturation.
REQ-012 W_ADDR SHALL equal wbin[ADDR_WIDTH-1:0], driven from register, no combinational path from W_INC.
REQ-013 W_EN SHALL equal W_INC AND NOT W_FULL, combinational.
REQ-014 W_PTR_GRAY SHALL be registered as gray(wbin_next), gray(b) = b XOR (b>>1); at most one bit changes per edge.
REQ-015 R_PTR_GRAY SHALL pass through a 2-flop synchroniser (rq2) before any use.
REQ-016 W_FULL SHALL be registered as (gray(wbin_next) == {~rq2[PW-1:PW-2], rq2[PW-3:0]}).
REQ-017 W_INC while W_FULL=1: ignored; wbin, W_PTR_GRAY unchanged, W_EN=0, no error flag.
REQ-018 Full release latency: R_PTR_GRAY change at edge N -> W_FULL deasserts at edge N+3 (2 sync + 1 flag).
REQ-019 Write accepted on edge filling the last slot SHALL set W_FULL at that same edge.
REQ-020 Read-pointer advance and accepted write in the same cycle: flag computed from post-write pointer and current rq2; conservative (may stay full up to 3 extra cycles), never falsely not-full.

Reset
REQ-021 W_RST=0 at an edge SHALL clear wbin, W_PTR_GRAY, rq2 stages, W_FULL to 0, overriding W_INC in that cycle.
REQ-022 After reset: W_ADDR=0, W_PTR_GRAY=0000, W_FULL=0, W_EN=W_INC.
REQ-023 Reset mid-operation SHALL discard the pointer state without reset-induced writes other than W_EN=W_INC combinationally (memory content irrelevant).

Configuration
REQ-024 Macro FIFO_ALMOST_FULL_EN: when defined, adds output W_ALMOST_FULL  output  1, registered.
REQ-025 With macro: W_ALMOST_FULL=1 when (wbin_next - gray2bin(rq2)) mod 2^PW >= depth-1; reset 0; also 1 when full.
REQ-026 Without macro: port, gray2bin logic and flop absent; all other behaviour identical.

Structure
REQ-027 Package fifo_pkg SHALL hold ADDR_WIDTH default, PW derivation, functions bin2gray and gray2bin; shared with read-side controller.
REQ-028 One sub-module: fifo_gray_sync (parameterised-width 2-flop synchroniser, sync active-low reset), reused by read side.
REQ-029 Estimated size 120-250 lines RTL including sub-module and package.

Verification
REQ-030 Reset: W_RST=0 for 2 edges with W_INC=1 -> W_ADDR=0, W_PTR_GRAY=0000, W_FULL=0.
REQ-031 Fill: R_PTR_GRAY=0000, W_INC=1 for 8 edges -> W_PTR_GRAY 0001,0011,0010,0110,0111,0101,0100,1100; W_FULL=1 at 8th edge; 9th request W_EN=0, W_ADDR stays 0.
REQ-032 Release: full state, R_PTR_GRAY -> 0001 at edge N -> W_FULL=0 at edge N+3, next write W_ADDR=0.
REQ-033 Wrap: 16 writes with R_PTR_GRAY tracking 4 entries behind -> W_PTR_GRAY returns 0000, W_ADDR 0, W_FULL never 1.
REQ-034 Mid-op reset: after 5 writes (W_ADDR=5), W_RST=0 with W_INC=1 -> next edge W_ADDR=0, W_PTR_GRAY=0000, W_FULL=0.
REQ-035 FIFO_ALMOST_FULL_EN defined, R_PTR_GRAY=0000: after 7 writes W_ALMOST_FULL=1, W_FULL=0; after 8th both 1.
